ascon_block_packer: RTL and testbench
=====================================

Name: ascon_block_packer

Overview:
- Front-end feeder for the Ascon-AEAD128 core. It accepts a byte stream for associated data or for plaintext/ciphertext and packs it into 128-bit blocks.
- It applies Ascon 10* padding and presents each block with its valid-byte count, last flag and pad flag.
- Downstream, the core control consumes each block through a valid/ready handshake.
- It drives the core's ad/db inputs, end-of-data timing and output-truncation length.

Parameters:
- BLOCK_BYTES, 16, bytes per block. Fixed at 16 for AEAD128; any other value is unsupported.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  packer accepts a beat this cycle
- in_data  input  8  message byte
- in_last  input  1  beat is the final beat of the message
- in_empty  input  1  qualifies a last beat carrying no byte (zero-length message); ignored unless in_last=1
- pad_empty  input  1  when set, a zero-length message produces a padding-only block; sampled on the empty beat
- out_valid  output  1  block valid
- out_ready  input  1  consumer accepts block
- out_block  output  128  packed block; byte i at bits [8i+7:8i]
- out_nbytes  output  5  message bytes in block, 0..16
- out_last  output  1  final block of message
- out_pad  output  1  block contains the 0x01 pad byte
- done  output  1  one-cycle pulse when the message is fully handed off

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=FILL, byte count=0, block register=0, out_valid=0, out_last=0, out_pad=0, out_nbytes=0, done=0. in_ready=1 once out of reset.
- Reset mid-operation discards the partial block and any pending padding block.
- Handshakes: an input beat transfers when in_valid & in_ready. A block transfers when out_valid & out_ready.
- out_* outputs are stable while out_valid=1 and out_ready=0.
- in_ready=1 only in FILL. out_valid=1 only in FULL and PADBLK.
- FILL:
  - Accepted non-empty byte at index k (0..15) is written to block bits [8k+7:8k]; count becomes k+1.
  - Not last, k<15: stay in FILL.
  - Not last, k=15: go to FULL with nbytes=16, last=0, pad=0. out_valid rises the cycle after acceptance.
  - Last, k<15: byte k+1 is set to 0x01 and bytes above k+1 are 0. Go to FULL with nbytes=k+1, last=1, pad=1.
  - Last, k=15: go to FULL with nbytes=16, last=0, pad=0, and set pend_pad.
  - Empty beat (in_last & in_empty) with count=0 and pad_empty=1: go to PADBLK.
  - Empty beat with count=0 and pad_empty=0: emit no block; pulse done next cycle; stay in FILL.
  - Empty beat with count>0 closes the current block exactly as "Last, k<15" does, using the current count; no byte is written.
- FULL, on out handshake:
  - If pend_pad is set: clear it and go to PADBLK.
  - Else if out_last=1: pulse done next cycle, clear block and count, go to FILL.
  - Else: clear block and count, go to FILL.
- PADBLK: presents out_block = 128'h01 (byte0=0x01, rest 0), nbytes=0, last=1, pad=1. On handshake: pulse done, clear state, go to FILL.
- Throughput: one bubble cycle per block, since in_ready=0 while a block is held.
- Latency: the block is visible 1 cycle after its closing beat.
- in_data is ignored on empty beats. in_empty is ignored when in_last=0.
- out_nbytes is 0 only for padding-only blocks.

Test Plan:
- 5 bytes 0xA0..0xA4 with last on 0xA4 -> one block 128'h01A4A3A2A1A0 (zero-extended), nbytes=5, last=1, pad=1; done 1 cycle after handshake.
- 16 bytes 0x00..0x0F, last on 0x0F -> block 128'h0F0E..0100 with nbytes=16, last=0, then block 128'h01 with nbytes=0, last=1, pad=1; done after the second block.
- 20 bytes with out_ready held low for 10 cycles after the first block -> first block stable, in_ready=0 throughout; second block nbytes=4 with pad byte 0x01 at byte 4.
- Empty beat with pad_empty=1 -> single block 128'h01, nbytes=0, last=1. Empty beat with pad_empty=0 -> no out_valid, one done pulse.
- 15 bytes then a separate empty last beat -> block nbytes=15, byte15=0x01, last=1, pad=1; no extra block.
- rst_n asserted low asynchronously after 7 bytes -> out_valid=0 immediately and in_ready=1 after release. A following 3-byte message yields nbytes=3 with no residue from the aborted bytes.

Source files
------------

// File: rtl/ascon_block_packer.sv
// Byte-to-block packer for the Ascon-AEAD128 core: gathers message bytes into
// 128-bit blocks, applies 10* padding and hands each block off over valid/ready.
module ascon_block_packer #(
  parameter int BLOCK_BYTES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  input  logic                       in_last,
  input  logic                       in_empty,
  input  logic                       pad_empty,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [8*BLOCK_BYTES-1:0]   out_block,
  output logic [4:0]                 out_nbytes,
  output logic                       out_last,
  output logic                       out_pad,
  output logic                       done
);

  localparam int BW = 8 * BLOCK_BYTES;
  localparam logic [BW-1:0] PAD_ONLY = {{(BW - 8){1'b0}}, 8'h01};
  localparam logic [4:0] LAST_IDX = 5'(BLOCK_BYTES - 1);
  localparam logic [4:0] FULL_CNT = 5'(BLOCK_BYTES);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_FULL   = 2'd1,
    S_PADBLK = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    count_q, count_d;
  logic [BW-1:0] block_q, block_d;
  logic [4:0]    nbytes_q, nbytes_d;
  logic          last_q, last_d;
  logic          pad_q, pad_d;
  logic          pend_pad_q, pend_pad_d;
  logic          done_q, done_d;

  logic          in_fire;
  logic          out_fire;
  logic          empty_beat;
  logic [6:0]    byte_idx;
  logic [6:0]    pad_idx;

  assign in_ready   = (state_q == S_FILL);
  assign out_valid  = (state_q == S_FULL) || (state_q == S_PADBLK);
  assign out_block  = block_q;
  assign out_nbytes = nbytes_q;
  assign out_last   = last_q;
  assign out_pad    = pad_q;
  assign done       = done_q;

  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign empty_beat = in_last & in_empty;
  // Bit offsets of the current byte slot and of the slot just after it.
  assign byte_idx   = {count_q[3:0], 3'b000};
  assign pad_idx    = {count_q[3:0] + 4'd1, 3'b000};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    block_d    = block_q;
    nbytes_d   = nbytes_q;
    last_d     = last_q;
    pad_d      = pad_q;
    pend_pad_d = pend_pad_q;
    done_d     = 1'b0;

    case (state_q)
      S_FILL: begin
        if (in_fire) begin
          if (empty_beat) begin
            if (count_q == 5'd0) begin
              if (pad_empty) begin
                block_d  = PAD_ONLY;
                nbytes_d = 5'd0;
                last_d   = 1'b1;
                pad_d    = 1'b1;
                state_d  = S_PADBLK;
              end else begin
                done_d = 1'b1;
              end
            end else begin
              // Close the partial block: the pad byte lands in the first free slot.
              block_d[byte_idx +: 8] = 8'h01;
              nbytes_d = count_q;
              last_d   = 1'b1;
              pad_d    = 1'b1;
              state_d  = S_FULL;
            end
          end else begin
            block_d[byte_idx +: 8] = in_data;
            count_d = count_q + 5'd1;
            if (count_q == LAST_IDX) begin
              // A message ending exactly on a block boundary needs a padding-only block.
              nbytes_d   = FULL_CNT;
              last_d     = 1'b0;
              pad_d      = 1'b0;
              pend_pad_d = in_last;
              state_d    = S_FULL;
            end else if (in_last) begin
              block_d[pad_idx +: 8] = 8'h01;
              nbytes_d = count_q + 5'd1;
              last_d   = 1'b1;
              pad_d    = 1'b1;
              state_d  = S_FULL;
            end
          end
        end
      end

      S_FULL: begin
        if (out_fire) begin
          if (pend_pad_q) begin
            pend_pad_d = 1'b0;
            block_d    = PAD_ONLY;
            nbytes_d   = 5'd0;
            last_d     = 1'b1;
            pad_d      = 1'b1;
            state_d    = S_PADBLK;
          end else begin
            done_d   = last_q;
            block_d  = '0;
            count_d  = 5'd0;
            nbytes_d = 5'd0;
            last_d   = 1'b0;
            pad_d    = 1'b0;
            state_d  = S_FILL;
          end
        end
      end

      S_PADBLK: begin
        if (out_fire) begin
          done_d     = 1'b1;
          block_d    = '0;
          count_d    = 5'd0;
          nbytes_d   = 5'd0;
          last_d     = 1'b0;
          pad_d      = 1'b0;
          pend_pad_d = 1'b0;
          state_d    = S_FILL;
        end
      end

      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FILL;
      count_q    <= 5'd0;
      block_q    <= '0;
      nbytes_q   <= 5'd0;
      last_q     <= 1'b0;
      pad_q      <= 1'b0;
      pend_pad_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      block_q    <= block_d;
      nbytes_q   <= nbytes_d;
      last_q     <= last_d;
      pad_q      <= pad_d;
      pend_pad_q <= pend_pad_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_ascon_block_packer.sv
// Directed bench for ascon_block_packer: hand-computed blocks, flags and done timing.
module tb_ascon_block_packer;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_empty;
  logic         pad_empty;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic [4:0]   out_nbytes;
  logic         out_last;
  logic         out_pad;
  logic         done;

  int n_cmp;
  int n_bad;

  ascon_block_packer #(.BLOCK_BYTES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_empty   (in_empty),
    .pad_empty  (pad_empty),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .out_nbytes (out_nbytes),
    .out_last   (out_last),
    .out_pad    (out_pad),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic empty,
                           input logic pe);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 128'(in_ready), 128'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    in_empty  = empty;
    pad_empty = pe;
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_empty  = 1'b0;
    pad_empty = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] first, input int len, input logic last);
    for (int i = 0; i < len; i++)
      send_beat(first + 8'(i), last && (i == len - 1), 1'b0, 1'b0);
  endtask

  task automatic take_block(input string tag, input logic [127:0] exp_blk,
                            input logic [4:0] exp_nb, input logic exp_last,
                            input logic exp_pad);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 128'(out_valid), 128'd1);
    check({tag, "_block"}, out_block, exp_blk);
    check({tag, "_nbytes"}, 128'(out_nbytes), 128'(exp_nb));
    check({tag, "_last"}, 128'(out_last), 128'(exp_last));
    check({tag, "_pad"}, 128'(out_pad), 128'(exp_pad));
    $display("block %s: data=%h nbytes=%0d last=%0b pad=%0b", tag, out_block, out_nbytes,
             out_last, out_pad);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] snap;
    logic         bad;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    in_empty = 1'b0;
    pad_empty = 1'b0;
    out_ready = 1'b0;

    #12;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_block", out_block, 128'd0);
    check("rst_nbytes", 128'(out_nbytes), 128'd0);
    check("rst_last_pad", 128'({out_last, out_pad}), 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 128'(in_ready), 128'd1);

    // 5-byte message
    send_seq(8'hA0, 5, 1'b1);
    check("t1_latency", 128'(out_valid), 128'd1);
    check("t1_in_ready_low", 128'(in_ready), 128'd0);
    take_block("t1", 128'h01A4A3A2A1A0, 5'd5, 1'b1, 1'b1);
    check("t1_done", 128'(done), 128'd1);
    tick();
    check("t1_done_pulse", 128'(done), 128'd0);

    // 16 bytes ending on a boundary -> data block then padding-only block
    send_seq(8'h00, 16, 1'b1);
    take_block("t2a", 128'h0F0E0D0C0B0A09080706050403020100, 5'd16, 1'b0, 1'b0);
    check("t2a_no_done", 128'(done), 128'd0);
    take_block("t2b", 128'h01, 5'd0, 1'b1, 1'b1);
    check("t2_done", 128'(done), 128'd1);

    // 20 bytes with backpressure on the first block
    send_seq(8'h10, 16, 1'b0);
    snap = out_block;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_block !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
    end
    check("t3_hold_stable", 128'(bad), 128'd0);
    take_block("t3a", 128'h1F1E1D1C1B1A19181716151413121110, 5'd16, 1'b0, 1'b0);
    check("t3a_no_done", 128'(done), 128'd0);
    send_seq(8'h20, 4, 1'b1);
    take_block("t3b", 128'h0123222120, 5'd4, 1'b1, 1'b1);
    check("t3_done", 128'(done), 128'd1);

    // zero-length message, with and without padding block
    send_beat(8'hEE, 1'b1, 1'b1, 1'b1);
    take_block("t4a", 128'h01, 5'd0, 1'b1, 1'b1);
    check("t4a_done", 128'(done), 128'd1);
    tick();
    send_beat(8'hEE, 1'b1, 1'b1, 1'b0);
    check("t4b_no_valid", 128'(out_valid), 128'd0);
    check("t4b_done", 128'(done), 128'd1);
    tick();
    check("t4b_done_pulse", 128'(done), 128'd0);
    check("t4b_still_idle", 128'(out_valid), 128'd0);
    $display("txn t4b: empty message without padding block");

    // 15 bytes, then a separate empty last beat
    send_seq(8'h30, 15, 1'b0);
    check("t5_no_early_block", 128'(out_valid), 128'd0);
    send_beat(8'hFF, 1'b1, 1'b1, 1'b0);
    take_block("t5", 128'h013E3D3C3B3A39383736353433323130, 5'd15, 1'b1, 1'b1);
    check("t5_done", 128'(done), 128'd1);
    tick();
    tick();
    check("t5_no_extra", 128'(out_valid), 128'd0);

    // asynchronous reset after 7 bytes
    send_seq(8'h40, 7, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 128'(out_valid), 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_in_ready", 128'(in_ready), 128'd1);
    $display("txn t6a: reset after 7 bytes");

    // asynchronous reset while a full block is held
    send_seq(8'h60, 16, 1'b0);
    check("t6b_held", 128'(out_valid), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6b_rst_valid", 128'(out_valid), 128'd0);
    check("t6b_rst_nbytes", 128'(out_nbytes), 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6b_in_ready", 128'(in_ready), 128'd1);
    $display("txn t6b: reset while block held");

    send_seq(8'h50, 3, 1'b1);
    take_block("t6c", 128'h01525150, 5'd3, 1'b1, 1'b1);
    check("t6c_done", 128'(done), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
